// File: rtl/pc_pkg.sv
// Shared types for the LC-3 PC unit: next-PC source selector.
package pc_pkg;

  localparam int PC_SEL_W = 2;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_INC = 2'd0,
    PC_EAB = 2'd1,
    PC_BUS = 2'd2,
    PC_RAS = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry: the write pointer simply advances and the count saturates.
// The caller never asks for a push and a pop in the same cycle. A combined
// push and pop is requested as a replace of the top entry.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_replace,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_ptr_dec;

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_ptr_dec = r_ptr - 1'b1;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_top   = o_empty ? '0 : r_mem[r_ptr];

  // Entry storage. No reset is needed because the count alone decides validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_ptr_inc] <= i_din;
    end else if (i_replace && !o_empty) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  // Top pointer and occupancy. A push on a full stack keeps the count at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
      if (!o_full) begin
        r_count <= r_count + 1'b1;
      end
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// LC-3 program-counter unit with an internal return-address stack.
// This module holds the PC register, the next-PC source mux and the sticky
// RAS error flags. The stack itself lives in pc_ras.
// The optional macro PC_HIST_EN records the PC value before each load on pc_prev.
// Without that macro, pc_prev is tied to zero.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int             W         = 16,
  parameter logic [W-1:0]   RST_VEC   = '0,
  parameter int             INC_STEP  = 1,
  parameter int             RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_pc,
  input  logic [PC_SEL_W-1:0] sel_pc,
  input  logic                push,
  input  logic [W-1:0]        eab_in,
  input  logic [W-1:0]        bus_in,
  input  logic                clr_err,
  output logic [W-1:0]        pc_out,
  output logic [W-1:0]        ras_top,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_unf,
  output logic [W-1:0]        pc_prev
);

  pc_sel_e      w_sel;
  logic [W-1:0] r_pc;
  logic [W-1:0] w_pc_next;
  logic [W-1:0] w_ret_addr;
  logic         w_is_ras;
  logic         w_ras_push;
  logic         w_ras_pop;
  logic         w_ras_repl;
  logic         w_set_ovf;
  logic         w_set_unf;
  logic         r_ovf;
  logic         r_unf;

  assign w_sel      = pc_sel_e'(sel_pc);
  assign w_ret_addr = r_pc + W'(INC_STEP);
  assign w_is_ras   = ld_pc && (w_sel == PC_RAS);

  // A combined push and pop on an empty stack falls back to a plain push
  // after the underflowing pop, so the stack ends up with one entry.
  assign w_ras_push = ld_pc && push && ((w_sel != PC_RAS) || ras_empty);
  assign w_ras_pop  = w_is_ras && !push && !ras_empty;
  assign w_ras_repl = w_is_ras && push && !ras_empty;
  assign w_set_ovf  = w_ras_push && ras_full;
  assign w_set_unf  = w_is_ras && ras_empty;

  pc_ras #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_ras_push),
    .i_pop     (w_ras_pop),
    .i_replace (w_ras_repl),
    .i_din     (w_ret_addr),
    .o_top     (ras_top),
    .o_empty   (ras_empty),
    .o_full    (ras_full)
  );

  // Next-PC source select. An empty RAS redirects to the bus.
  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      PC_INC:  w_pc_next = w_ret_addr;
      PC_EAB:  w_pc_next = eab_in;
      PC_BUS:  w_pc_next = bus_in;
      PC_RAS:  w_pc_next = ras_empty ? bus_in : ras_top;
      default: w_pc_next = r_pc;
    endcase
  end

  // PC register. It updates only on ld_pc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RST_VEC;
    end else if (ld_pc) begin
      r_pc <= w_pc_next;
    end
  end

  // Sticky overflow and underflow flags. A clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clr_err) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_set_ovf;
      r_unf <= r_unf | w_set_unf;
    end
  end

  assign pc_out  = r_pc;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

`ifdef PC_HIST_EN
  logic [W-1:0] r_pc_prev;

  // Remembers the PC that was replaced by the most recent load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc_prev <= '0;
    end else if (ld_pc) begin
      r_pc_prev <= r_pc;
    end
  end

  assign pc_prev = r_pc_prev;
`else
  assign pc_prev = '0;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit (W=16, RST_VEC=0, INC_STEP=1, RAS_DEPTH=4).
// An independent queue-based model pushes expected state when stimulus is driven.
// Each test task pops the expected state after the clock edge and compares it.
module tb_pc_ras_unit;
  import pc_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic        ld;
    logic [1:0]  sel;
    logic        push;
    logic [15:0] eab;
    logic [15:0] bus;
    logic        clr;
  } stim_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] top;
    logic [15:0] prev;
    logic [3:0]  fl;   // {empty, full, ovf, unf}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_pc;
  logic [1:0]  sel_pc;
  logic        push;
  logic [15:0] eab_in;
  logic [15:0] bus_in;
  logic        clr_err;
  logic [15:0] pc_out;
  logic [15:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;
  logic [15:0] pc_prev;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic [15:0] m_prev;
  logic        m_ovf;
  logic        m_unf;

  pc_ras_unit #(
    .W         (16),
    .RST_VEC   (16'h0000),
    .INC_STEP  (1),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_pc     (ld_pc),
    .sel_pc    (sel_pc),
    .push      (push),
    .eab_in    (eab_in),
    .bus_in    (bus_in),
    .clr_err   (clr_err),
    .pc_out    (pc_out),
    .ras_top   (ras_top),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .pc_prev   (pc_prev)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic ld, input logic [1:0] sel, input logic ps,
                               input logic [15:0] eab, input logic [15:0] bus,
                               input logic clr);
    stim_t s;
    s.ld = ld; s.sel = sel; s.push = ps; s.eab = eab; s.bus = bus; s.clr = clr;
    return s;
  endfunction

  task automatic expect_now();
    exp_t e;
    e.pc  = m_pc;
    e.top = (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 16'h0000;
    e.fl  = {m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_unf};
`ifdef PC_HIST_EN
    e.prev = m_prev;
`else
    e.prev = 16'h0000;
`endif
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_prev = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
    m_stk.delete();
  endtask

  // Drive one cycle, advance the model, queue its expectation, and step past the edge.
  task automatic drive(input stim_t s);
    logic [15:0] ret;
    logic [15:0] npc;
    ld_pc = s.ld; sel_pc = s.sel; push = s.push;
    eab_in = s.eab; bus_in = s.bus; clr_err = s.clr;
    if (s.ld) begin
      ret = m_pc + 16'd1;
      npc = m_pc;
      case (s.sel)
        2'd0: npc = ret;
        2'd1: npc = s.eab;
        2'd2: npc = s.bus;
        default: begin
          if (m_stk.size() == 0) begin
            npc = s.bus;
            m_unf = 1'b1;
            if (s.push) m_stk.push_back(ret);
          end else if (s.push) begin
            npc = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = ret;
          end else begin
            npc = m_stk.pop_back();
          end
        end
      endcase
      if (s.push && s.sel != 2'd3) begin
        if (m_stk.size() == DEPTH) begin
          m_ovf = 1'b1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back(ret);
      end
      m_prev = m_pc;
      m_pc   = npc;
    end
    if (s.clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    expect_now();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    exp_t  e;
    rst = 1'b0; ld_pc = 0; sel_pc = 0; push = 0; eab_in = 0; bus_in = 0; clr_err = 0;
    model_reset();
    expect_now();
    #12;
    e = sb.pop_front();
    n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL reset_init pc_out got %h want %h", pc_out, e.pc); end
    n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL reset_init flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL reset_init ras_top got %h want %h", ras_top, e.top); end
    n_chk++; if (pc_prev !== e.prev) begin n_fail++; $display("FAIL reset_init pc_prev got %h want %h", pc_prev, e.prev); end
    @(posedge clk); #1;
    rst = 1'b1;
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0000, 16'h1000, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, PC_EAB, 1, 16'h2000 + 16'(i), 16'h0, 0));
    tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'h0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      $display("txn reset[%0d] pc=%h top=%h fl=%b", i, pc_out, ras_top, {ras_empty, ras_full, ras_ovf, ras_unf});
      n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL reset pc_out got %h want %h", pc_out, e.pc); end
      n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL reset ras_top got %h want %h", ras_top, e.top); end
      n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL reset flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    end
    // Apply an asynchronous reset in the middle of a cycle while the RAS holds entries.
    ld_pc = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    expect_now();
    e = sb.pop_front();
    n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL async_reset pc_out got %h want %h", pc_out, e.pc); end
    n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL async_reset flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL async_reset ras_top got %h want %h", ras_top, e.top); end
    n_chk++; if (pc_prev !== e.prev) begin n_fail++; $display("FAIL async_reset pc_prev got %h want %h", pc_prev, e.prev); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Generic table runner body, repeated per scenario with its own tag.
  task automatic test_inc();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0, 16'h3000, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, PC_INC, 0, 16'h0, 16'h0, 0));
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0, 16'hFFFF, 0));
    tbl.push_back(mk(1, PC_INC, 0, 16'h0, 16'h0, 0));
    tbl.push_back(mk(0, PC_EAB, 1, 16'hAAAA, 16'h0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      $display("txn inc[%0d] pc=%h top=%h", i, pc_out, ras_top);
      n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL inc pc_out got %h want %h", pc_out, e.pc); end
      n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL inc ras_top got %h want %h", ras_top, e.top); end
      n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL inc flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    end
  endtask

  task automatic test_call_ret();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0, 16'h3010, 0));
    tbl.push_back(mk(1, PC_EAB, 1, 16'h4000, 16'h0, 0));
    tbl.push_back(mk(0, PC_RAS, 1, 16'h0, 16'h0, 0));
    tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'hBEEF, 0));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      $display("txn call_ret[%0d] pc=%h top=%h", i, pc_out, ras_top);
      n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL call_ret pc_out got %h want %h", pc_out, e.pc); end
      n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL call_ret ras_top got %h want %h", ras_top, e.top); end
      n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL call_ret flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    end
  endtask

  task automatic test_overflow();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0, 16'h1000, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, PC_EAB, 1, 16'h2000 + 16'(i * 16'h100), 16'h0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'h7777, 0));
    tbl.push_back(mk(0, PC_INC, 0, 16'h0, 16'h0, 1));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      $display("txn overflow[%0d] pc=%h top=%h fl=%b", i, pc_out, ras_top, {ras_empty, ras_full, ras_ovf, ras_unf});
      n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL overflow pc_out got %h want %h", pc_out, e.pc); end
      n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL overflow ras_top got %h want %h", ras_top, e.top); end
      n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL overflow flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
    end
  endtask

  task automatic test_push_pop();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(mk(1, PC_BUS, 0, 16'h0, 16'h4FFF, 1));
    tbl.push_back(mk(1, PC_EAB, 1, 16'h6000, 16'h0, 0));   // top=0x5000, PC=0x6000
    tbl.push_back(mk(1, PC_RAS, 1, 16'h0, 16'h0, 0));      // PC=0x5000, top=0x6001
    tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'h0, 0));      // pop 0x6001, empty
    tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'h0AB0, 1));   // unf event with clr
    tbl.push_back(mk(1, PC_RAS, 0, 16'h0, 16'h0AC0, 0));   // unf sets
    tbl.push_back(mk(1, PC_RAS, 1, 16'h0, 16'h1234, 1));   // empty pop+push with clr
    tbl.push_back(mk(1, PC_RAS, 1, 16'h0, 16'h5678, 0));   // replace top
    tbl.push_back(mk(1, PC_EAB, 0, 16'h3000, 16'h0, 0));
    tbl.push_back(mk(1, PC_EAB, 0, 16'h4000, 16'h0, 0));   // pc_prev=0x3000 when enabled
    foreach (tbl[i]) begin
      drive(tbl[i]);
      e = sb.pop_front();
      $display("txn push_pop[%0d] pc=%h top=%h fl=%b prev=%h", i, pc_out, ras_top, {ras_empty, ras_full, ras_ovf, ras_unf}, pc_prev);
      n_chk++; if (pc_out !== e.pc) begin n_fail++; $display("FAIL push_pop pc_out got %h want %h", pc_out, e.pc); end
      n_chk++; if (ras_top !== e.top) begin n_fail++; $display("FAIL push_pop ras_top got %h want %h", ras_top, e.top); end
      n_chk++; if ({ras_empty, ras_full, ras_ovf, ras_unf} !== e.fl) begin n_fail++; $display("FAIL push_pop flags got %b want %b", {ras_empty, ras_full, ras_ovf, ras_unf}, e.fl); end
      n_chk++; if (pc_prev !== e.prev) begin n_fail++; $display("FAIL push_pop pc_prev got %h want %h", pc_prev, e.prev); end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_call_ret();
    test_overflow();
    test_push_pop();
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard leftover got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
